// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_write_arbiter
// Purpose  : Packet-atomic round-robin arbiter sharing one FIFO write port.
//            A packet is granted only when the FIFO can hold all of it.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter #(
    parameter int WIDTH     = 8,
    parameter int N_REQ     = 2,
    parameter int DEPTH     = 16,
    parameter int MAX_LEN   = 16,
    localparam int LEN_BITS  = $clog2(MAX_LEN + 1),
    localparam int FREE_BITS = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid_i,
    input  logic [N_REQ*LEN_BITS-1:0] req_len_i,
    output logic [N_REQ-1:0]          grant_o,
    input  logic [N_REQ-1:0]          src_valid_i,
    input  logic [N_REQ*WIDTH-1:0]    src_data_i,
    output logic [N_REQ-1:0]          src_ready_o,
    output logic [N_REQ-1:0]          done_o,
    output logic                      fifo_wr_en_o,
    output logic [WIDTH-1:0]          fifo_wr_data_o,
    input  logic [FREE_BITS-1:0]      fifo_free_i,
    input  logic                      fifo_full_i,
    output logic                      busy_o
);

    localparam int IDX_BITS = $clog2(N_REQ);

    localparam logic [LEN_BITS-1:0] c_max_len  = LEN_BITS'(MAX_LEN);
    localparam logic [LEN_BITS-1:0] c_len_one  = LEN_BITS'(1);
    localparam logic [IDX_BITS-1:0] c_idx_one  = IDX_BITS'(1);
    localparam logic [IDX_BITS-1:0] c_last_idx = IDX_BITS'(N_REQ - 1);
    localparam logic [IDX_BITS:0]   c_nreq     = (IDX_BITS + 1)'(N_REQ);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_BITS-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_BITS-1:0]   gsel_q, gsel_d;
    logic [LEN_BITS-1:0]   remaining_q, remaining_d;
    logic [N_REQ-1:0]      grant_q, grant_d;

    logic [LEN_BITS-1:0]   w_len  [N_REQ];
    logic [WIDTH-1:0]      w_data [N_REQ];
    logic [IDX_BITS:0]     w_scan_ext;
    logic [IDX_BITS-1:0]   w_scan_sel;
    logic [IDX_BITS-1:0]   w_cand;
    logic                  w_found;
    logic                  w_fit;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_len[g]  = req_len_i[g*LEN_BITS +: LEN_BITS];
        assign w_data[g] = src_data_i[g*WIDTH +: WIDTH];
    end

    // First legal requester at or after rr_ptr wins the scan, even if it
    // does not fit yet: nobody may overtake it.
    always_comb begin
        w_found    = 1'b0;
        w_cand     = rr_ptr_q;
        w_scan_ext = '0;
        w_scan_sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan_ext = {1'b0, rr_ptr_q} + (IDX_BITS + 1)'(k);
            if (w_scan_ext >= c_nreq) begin
                w_scan_ext = w_scan_ext - c_nreq;
            end
            w_scan_sel = w_scan_ext[IDX_BITS-1:0];
            if (!w_found && req_valid_i[w_scan_sel] &&
                (w_len[w_scan_sel] != '0) && (w_len[w_scan_sel] <= c_max_len)) begin
                w_found = 1'b1;
                w_cand  = w_scan_sel;
            end
        end
        w_fit = w_found && (32'(w_len[w_cand]) <= 32'(fifo_free_i));
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        gsel_d         = gsel_q;
        remaining_d    = remaining_q;
        grant_d        = grant_q;
        src_ready_o    = '0;
        done_o         = '0;
        fifo_wr_en_o   = 1'b0;
        fifo_wr_data_o = '0;
        case (state_q)
            S_IDLE: begin
                if (w_fit) begin
                    state_d         = S_XFER;
                    gsel_d          = w_cand;
                    remaining_d     = w_len[w_cand];
                    grant_d         = '0;
                    grant_d[w_cand] = 1'b1;
                end
            end
            S_XFER: begin
                src_ready_o[gsel_q] = ~fifo_full_i;
                if (src_valid_i[gsel_q] && !fifo_full_i) begin
                    fifo_wr_en_o   = 1'b1;
                    fifo_wr_data_o = w_data[gsel_q];
                    remaining_d    = remaining_q - c_len_one;
                    if (remaining_q == c_len_one) begin
                        done_o[gsel_q] = 1'b1;
                        state_d        = S_IDLE;
                        grant_d        = '0;
                        rr_ptr_d       = (gsel_q == c_last_idx) ? '0 : gsel_q + c_idx_one;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            gsel_q      <= '0;
            remaining_q <= '0;
            grant_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gsel_q      <= gsel_d;
            remaining_q <= remaining_d;
            grant_q     <= grant_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q == S_XFER);

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_write_arbiter
// Purpose  : Directed self-checking bench with a per-cycle reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid, src_valid, grant, src_ready, done;
    logic [4:0]  len0, len1;
    logic [7:0]  d0, d1;
    logic [9:0]  req_len;
    logic [15:0] src_data;
    logic        wr_en, fifo_full, busy;
    logic [7:0]  wr_data;
    logic [4:0]  fifo_free;

    assign req_len  = {len1, len0};
    assign src_data = {d1, d0};

    fifo_write_arbiter #(.WIDTH(8), .N_REQ(2), .DEPTH(16), .MAX_LEN(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_len_i(req_len), .grant_o(grant),
        .src_valid_i(src_valid), .src_data_i(src_data), .src_ready_o(src_ready),
        .done_o(done), .fifo_wr_en_o(wr_en), .fifo_wr_data_o(wr_data),
        .fifo_free_i(fifo_free), .fifo_full_i(fifo_full), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port and how many beats are still owed.
    bit m_busy;
    int m_owner, m_left, m_ptr;

    function automatic int ln(input int i);
        return (i == 0) ? int'(len0) : int'(len1);
    endfunction

    function automatic bit legal(input int i);
        return req_valid[i] && ln(i) >= 1 && ln(i) <= 16;
    endfunction

    function automatic int cand();
        for (int k = 0; k < 2; k++) begin
            if (legal((m_ptr + k) % 2)) return (m_ptr + k) % 2;
        end
        return -1;
    endfunction

    function automatic bit m_beat();
        return m_busy && src_valid[m_owner] && !fifo_full;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_owner <= 0; m_left <= 0; m_ptr <= 0;
        end else if (m_busy) begin
            if (m_beat()) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_ptr  <= (m_owner + 1) % 2;
                end
            end
        end else if (cand() >= 0 && ln(cand()) <= int'(fifo_free)) begin
            m_busy  <= 1'b1;
            m_owner <= cand();
            m_left  <= ln(cand());
        end
    end

    always @(negedge clk) begin
        chk("grant",     grant,     m_busy ? (1 << m_owner) : 0);
        chk("busy",      busy,      m_busy);
        chk("src_ready", src_ready, (m_busy && !fifo_full) ? (1 << m_owner) : 0);
        chk("wr_en",     wr_en,     m_beat());
        chk("wr_data",   wr_data,   m_beat() ? ((m_owner == 0) ? d0 : d1) : 8'h00);
        chk("done",      done,      (m_beat() && m_left == 1) ? (1 << m_owner) : 0);
    end

    // Requester emulation: pend = packets still to send, cnt = beats sent.
    int         pend[2], cnt[2];
    logic [7:0] base[2];
    logic [1:0] sched_v[$];
    logic       sched_f[$];
    int         log_cyc[$];
    logic [7:0] log_dat[$];
    logic [1:0] g_log[$];
    int         cyc, done0_cyc, done1_cyc;

    task automatic clr();
        log_cyc.delete(); log_dat.delete(); g_log.delete();
        cyc = 0; done0_cyc = -1; done1_cyc = -1;
    endtask

    task automatic start(input logic [4:0] l0, l1, input int p0, p1, input logic [7:0] b0, b1);
        len0 = l0; len1 = l1; pend[0] = p0; pend[1] = p1;
        base[0] = b0; base[1] = b1; cnt[0] = 0; cnt[1] = 0;
        clr();
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            req_valid = {pend[1] > 0, pend[0] > 0};
            d0 = 8'(base[0] + 8'(cnt[0]));
            d1 = 8'(base[1] + 8'(cnt[1]));
            src_valid = (sched_v.size() > 0) ? sched_v.pop_front() : 2'b11;
            fifo_full = (sched_f.size() > 0) ? sched_f.pop_front() : 1'b0;
            @(negedge clk);
            g_log.push_back(grant);
            if (wr_en) begin
                log_cyc.push_back(cyc);
                log_dat.push_back(wr_data);
            end
            for (int i = 0; i < 2; i++) begin
                if (src_ready[i] && src_valid[i]) cnt[i]++;
                if (done[i]) pend[i]--;
            end
            if (done[0]) done0_cyc = cyc;
            if (done[1]) done1_cyc = cyc;
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_log(input string nm, input int k, input int ec, input logic [7:0] ed);
        if (k < log_cyc.size()) begin
            chk({nm, "_cycle"}, log_cyc[k], ec);
            chk({nm, "_data"},  log_dat[k], ed);
        end else begin
            chk({nm, "_missing"}, 32'hFFFF_FFFF, ec);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_grant"}, grant, 0);
        chk({nm, "_busy"},  busy, 0);
        chk({nm, "_ready"}, src_ready, 0);
        chk({nm, "_wr_en"}, wr_en, 0);
        chk({nm, "_data"},  wr_data, 0);
        chk({nm, "_done"},  done, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        req_valid = 0; src_valid = 0; len0 = 0; len1 = 0; d0 = 0; d1 = 0;
        fifo_free = 5'd16; fifo_full = 0;
        pend[0] = 0; pend[1] = 0; cnt[0] = 0; cnt[1] = 0;
        #1;
        do_reset();

        // 1: single len-4 packet, back-to-back beats
        start(4, 0, 1, 0, 8'hA0, 8'h00);
        run(6);
        chk("t1_grant_c0", g_log[0], 2'b00);
        chk("t1_grant_c1", g_log[1], 2'b01);
        chk("t1_grant_c5", g_log[5], 2'b00);
        chk("t1_writes", log_cyc.size(), 4);
        for (int k = 0; k < 4; k++) chk_log("t1_beat", k, k + 1, 8'(8'hA0 + k));
        chk("t1_done_cycle", done0_cyc, 4);

        // 2: both request; req0 re-requests but the pointer has rotated
        do_reset();
        start(2, 3, 2, 1, 8'hB0, 8'hC0);
        run(11);
        chk("t2_writes", log_cyc.size(), 7);
        chk_log("t2_r0a", 0, 1, 8'hB0);
        chk_log("t2_r0b", 1, 2, 8'hB1);
        chk_log("t2_r1a", 2, 4, 8'hC0);
        chk_log("t2_r1c", 4, 6, 8'hC2);
        chk_log("t2_r0c", 5, 8, 8'hB2);
        chk_log("t2_r0d", 6, 9, 8'hB3);

        // 3: head-of-line candidate does not fit, no bypass
        do_reset();
        fifo_free = 5'd3;
        start(4, 2, 1, 1, 8'hD0, 8'hD8);
        run(4);
        chk("t3_no_writes", log_cyc.size(), 0);
        chk("t3_no_grant", g_log[3], 2'b00);
        fifo_free = 5'd4;
        clr();
        run(9);
        chk("t3_writes", log_cyc.size(), 6);
        chk_log("t3_r0", 0, 1, 8'hD0);
        chk_log("t3_r1", 4, 6, 8'hD8);

        // 4: gaps in src_valid, non-granted requester strobing valid
        do_reset();
        fifo_free = 5'd16;
        start(3, 0, 1, 0, 8'hE0, 8'hE8);
        sched_v = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b01};
        run(8);
        chk("t4_writes", log_cyc.size(), 3);
        chk_log("t4_b0", 0, 1, 8'hE0);
        chk_log("t4_b1", 1, 4, 8'hE1);
        chk_log("t4_b2", 2, 5, 8'hE2);
        chk("t4_done_cycle", done0_cyc, 5);

        // 5: reset mid-packet while req1 owns the port (pointer at 1)
        start(2, 5, 0, 1, 8'hF0, 8'hF8);
        run(3);
        chk("t5_pre_writes", log_cyc.size(), 2);
        rst = 1'b1;
        #2;
        chk_reset_outputs("t5_async");
        @(posedge clk); #1;
        rst = 1'b0;
        start(2, 2, 1, 1, 8'hF0, 8'hF8);
        run(7);
        chk("t5_writes", log_cyc.size(), 4);
        chk_log("t5_r0", 0, 1, 8'hF0);
        chk_log("t5_r1", 2, 4, 8'hF8);

        // 6: zero-length and over-length requests are skipped
        do_reset();
        start(0, 2, 1, 1, 8'h60, 8'h68);
        run(5);
        chk("t6_writes", log_cyc.size(), 2);
        chk_log("t6_r1", 0, 1, 8'h68);
        chk("t6_r0_pending", pend[0], 1);
        start(17, 1, 1, 1, 8'h60, 8'h70);
        run(4);
        chk("t6b_writes", log_cyc.size(), 1);
        chk_log("t6b_r1", 0, 1, 8'h70);

        // 7: fifo_full during a transfer holds the beat back
        do_reset();
        start(2, 0, 1, 0, 8'h30, 8'h00);
        sched_f = '{1'b0, 1'b1, 1'b0, 1'b0};
        run(5);
        chk("t7_writes", log_cyc.size(), 2);
        chk_log("t7_b0", 0, 2, 8'h30);
        chk_log("t7_b1", 1, 3, 8'h31);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
